freq_ramp_ctrl: RTL and testbench

//  Run/stop and accel/decel sequencer for the VFD output frequency. Sits between the
//  HMI frequency setpoint (freq_gen output, 0..999 Hz) and the modulator. Slews the

---
 rtl/freq_ramp_ctrl_pkg.sv | 56 +++++
 rtl/freq_ramp_ctrl_prescaler.sv | 34 +++
 rtl/freq_ramp_ctrl.sv | 102 ++++++++++
 tb/tb_freq_ramp_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_ramp_ctrl_pkg.sv
// Shared definitions for the VFD frequency ramp sequencer: state codes, frequency
// limit, setpoint clamp and the run/stop transition rules.
package freq_ramp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCEL = 3'd1,
    ST_RUN   = 3'd2,
    ST_DECEL = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [9:0] FREQ_MAX = 10'd999;

  function automatic logic [9:0] clamp_freq(input logic [9:0] f);
    return (f > FREQ_MAX) ? FREQ_MAX : f;
  endfunction

  // Transitions look only at the registered frequency, never at the step in flight.
  function automatic state_t next_state(
    input state_t     st,
    input logic [9:0] tgt,
    input logic [9:0] freq,
    input logic       run_en,
    input logic       estop
  );
    state_t ns;
    ns = st;
    if (estop) begin
      ns = ST_FAULT;
    end else begin
      case (st)
        ST_IDLE:  ns = run_en ? ST_ACCEL : ST_IDLE;
        ST_ACCEL: begin
          if (tgt < freq)       ns = ST_DECEL;
          else if (tgt == freq) ns = ST_RUN;
          else                  ns = ST_ACCEL;
        end
        ST_RUN: begin
          if (tgt > freq)       ns = ST_ACCEL;
          else if (tgt < freq)  ns = ST_DECEL;
          else                  ns = ST_RUN;
        end
        ST_DECEL: begin
          if (tgt > freq)       ns = ST_ACCEL;
          else if (tgt == freq) ns = ((tgt == 10'd0) && !run_en) ? ST_IDLE : ST_RUN;
          else                  ns = ST_DECEL;
        end
        ST_FAULT: ns = run_en ? ST_FAULT : ST_IDLE;
        default:  ns = ST_FAULT;
      endcase
    end
    return ns;
  endfunction

endpackage

// File: rtl/freq_ramp_ctrl_prescaler.sv
// Ramp-rate prescaler: free-runs 0..RAMP_DIV-1 while enabled, one tick per wrap.
module ramp_prescaler
  import freq_ramp_ctrl_pkg::*;
#(
  parameter int RAMP_DIV = 50000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CW       = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(RAMP_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Step counter; held at zero outside the ramp states and restarted on a state change.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || !en) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/freq_ramp_ctrl.sv
// Run/stop and accel/decel sequencer: slews the applied VFD frequency toward the
// clamped setpoint at a fixed step rate, with emergency stop to a latched fault.
module freq_ramp_ctrl
  import freq_ramp_ctrl_pkg::*;
#(
  parameter int RAMP_DIV = 50000,
  parameter int ACC_STEP = 1,
  parameter int DEC_STEP = 2
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [9:0] freq_set,
  input  logic       run_en,
  input  logic       estop,
  output logic [9:0] freq_out,
  output logic [2:0] state,
  output logic       running,
  output logic       at_speed,
  output logic       fault
);

  localparam logic [9:0] ACC_W = 10'(ACC_STEP);
  localparam logic [9:0] DEC_W = 10'(DEC_STEP);

  state_t     r_state;
  logic [9:0] r_freq;
  logic       r_running;
  logic       r_at_speed;
  logic       r_fault;

  state_t     w_state_nxt;
  logic [9:0] w_tgt;
  logic [9:0] w_up_dist;
  logic [9:0] w_dn_dist;
  logic       w_state_chg;
  logic       w_ramp_en;
  logic       w_tick;

  assign w_tgt       = run_en ? clamp_freq(freq_set) : 10'd0;
  assign w_up_dist   = w_tgt - r_freq;
  assign w_dn_dist   = r_freq - w_tgt;
  assign w_state_nxt = next_state(r_state, w_tgt, r_freq, run_en, estop);
  assign w_state_chg = (w_state_nxt != r_state);
  assign w_ramp_en   = (r_state == ST_ACCEL) || (r_state == ST_DECEL);

  ramp_prescaler #(
    .RAMP_DIV (RAMP_DIV)
  ) u_prescaler (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .en      (w_ramp_en),
    .clr     (w_state_chg),
    .tick    (w_tick)
  );

  // Sequencer: state, applied frequency and status flags, all updated on the same edge.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_freq     <= 10'd0;
      r_running  <= 1'b0;
      r_at_speed <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= (w_state_nxt == ST_ACCEL) || (w_state_nxt == ST_RUN) ||
                    (w_state_nxt == ST_DECEL);
      r_at_speed <= (w_state_nxt == ST_RUN);
      r_fault    <= (w_state_nxt == ST_FAULT);
      if (estop) begin
        r_freq <= 10'd0;
      end else begin
        // Steps are clipped to the remaining distance, so the target is never crossed.
        case (r_state)
          ST_ACCEL: begin
            if (w_tick && (w_tgt > r_freq)) begin
              r_freq <= r_freq + ((w_up_dist < ACC_W) ? w_up_dist : ACC_W);
            end else begin
              r_freq <= r_freq;
            end
          end
          ST_DECEL: begin
            if (w_tick && (w_tgt < r_freq)) begin
              r_freq <= r_freq - ((w_dn_dist < DEC_W) ? w_dn_dist : DEC_W);
            end else begin
              r_freq <= r_freq;
            end
          end
          ST_RUN:  r_freq <= r_freq;
          default: r_freq <= 10'd0;
        endcase
      end
    end
  end

  assign freq_out = r_freq;
  assign state    = r_state;
  assign running  = r_running;
  assign at_speed = r_at_speed;
  assign fault    = r_fault;

endmodule

// File: tb/tb_freq_ramp_ctrl.sv
// Self-checking bench for freq_ramp_ctrl: two parameterisations driven by shared
// directed and random stimulus, compared every cycle against a behavioural model.
module tb_freq_ramp_ctrl;

  localparam int DIV = 4;

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] freq_set = 10'd0;
  logic       run_en  = 1'b0;
  logic       estop   = 1'b0;

  logic [9:0] fo0, fo1;
  logic [2:0] st0, st1;
  logic       rn0, rn1, as0, as1, ft0, ft1;

  int n_checks = 0;
  int n_errors = 0;

  // model state per unit: state code, frequency, cycles spent in current state
  int m_st[2], m_fq[2], m_age[2];
  int n_st[2], n_fq[2], n_age[2];
  int p_acc[2] = '{5, 500};
  int p_dec[2] = '{10, 10};

  freq_ramp_ctrl #(.RAMP_DIV(DIV), .ACC_STEP(5), .DEC_STEP(10)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .freq_set(freq_set), .run_en(run_en),
    .estop(estop), .freq_out(fo0), .state(st0), .running(rn0),
    .at_speed(as0), .fault(ft0)
  );

  freq_ramp_ctrl #(.RAMP_DIV(DIV), .ACC_STEP(500), .DEC_STEP(10)) dut_big (
    .clk_sys(clk_sys), .rst_n(rst_n), .freq_set(freq_set), .run_en(run_en),
    .estop(estop), .freq_out(fo1), .state(st1), .running(rn1),
    .at_speed(as1), .fault(ft1)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_next(input int k);
    int tgt, f, s, ns, nf;
    bit tk;
    f  = m_fq[k];
    s  = m_st[k];
    tgt = run_en ? imin(int'(freq_set), 999) : 0;
    tk = (s == 1 || s == 3) && ((m_age[k] % DIV) == DIV - 1);
    ns = s;
    nf = f;
    if (estop) begin
      ns = 4; nf = 0;
    end else if (s == 0) begin
      ns = run_en ? 1 : 0; nf = 0;
    end else if (s == 1) begin
      ns = (tgt < f) ? 3 : (tgt == f) ? 2 : 1;
      if (tk && tgt > f) nf = f + imin(p_acc[k], tgt - f);
    end else if (s == 2) begin
      ns = (tgt > f) ? 1 : (tgt < f) ? 3 : 2;
    end else if (s == 3) begin
      if (tgt > f) ns = 1;
      else if (tgt == f) ns = (tgt == 0 && !run_en) ? 0 : 2;
      if (tk && tgt < f) nf = f - imin(p_dec[k], f - tgt);
    end else begin
      ns = run_en ? 4 : 0; nf = 0;
    end
    if (!rst_n) begin
      ns = 0; nf = 0;
    end
    n_st[k]  = ns;
    n_fq[k]  = nf;
    n_age[k] = (ns != s) ? 0 : m_age[k] + 1;
  endtask

  task automatic check_unit(input string nm, input int k, input int f, input int s,
                            input int r, input int a, input int fl);
    check({nm, "_freq"}, f, m_fq[k]);
    check({nm, "_state"}, s, m_st[k]);
    check({nm, "_running"}, r, int'(m_st[k] >= 1 && m_st[k] <= 3));
    check({nm, "_at_speed"}, a, int'(m_st[k] == 2));
    check({nm, "_fault"}, fl, int'(m_st[k] == 4));
    check({nm, "_le_max"}, int'(f > 999), 0);
  endtask

  task automatic check_all();
    check_unit("u0", 0, int'(fo0), int'(st0), int'(rn0), int'(as0), int'(ft0));
    check_unit("u1", 1, int'(fo1), int'(st1), int'(rn1), int'(as1), int'(ft1));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_fq[k] = 0; m_age[k] = 0;
    end
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) model_next(k);
    @(posedge clk_sys);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = n_st[k]; m_fq[k] = n_fq[k]; m_age[k] = n_age[k];
    end
    check_all();
  endtask

  initial begin
    int ramp_vals[5];
    ramp_vals = '{5, 10, 15, 20, 23};
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    check_all();
    rst_n = 1'b1;

    // ramp up to 23 in steps of 5
    freq_set = 10'd23; run_en = 1'b1;
    cycle();
    check("accel_entry", int'(st0), 1);
    for (int i = 0; i < 5; i++) begin
      repeat (DIV) cycle();
      check("ramp_up", int'(fo0), ramp_vals[i]);
    end
    cycle();
    check("run_state", int'(st0), 2);
    check("run_at_speed", int'(as0), 1);

    // setpoint drop to 3
    freq_set = 10'd3;
    cycle();
    check("decel_entry", int'(st0), 3);
    repeat (DIV) cycle();
    check("ramp_dn_13", int'(fo0), 13);
    repeat (DIV) cycle();
    check("ramp_dn_3", int'(fo0), 3);
    cycle();
    check("run_at_3", int'(st0), 2);

    // run dropped: ramp to zero then idle
    run_en = 1'b0;
    cycle();
    check("stop_decel", int'(st0), 3);
    repeat (DIV) cycle();
    check("stop_freq0", int'(fo0), 0);
    cycle();
    check("stop_idle", int'(st0), 0);
    check("stop_running", int'(rn0), 0);

    // emergency stop during accel
    freq_set = 10'd23; run_en = 1'b1;
    cycle();
    repeat (2 * DIV) cycle();
    check("pre_estop_freq", int'(fo0), 10);
    estop = 1'b1;
    cycle();
    check("estop_state", int'(st0), 4);
    check("estop_freq", int'(fo0), 0);
    check("estop_fault", int'(ft0), 1);
    estop = 1'b0;
    repeat (2) cycle();
    check("fault_hold", int'(st0), 4);
    run_en = 1'b0;
    cycle();
    check("fault_exit", int'(st0), 0);

    // over-range setpoint with large accel step
    freq_set = 10'd1023; run_en = 1'b1;
    cycle();
    repeat (DIV) cycle();
    check("big_500", int'(fo1), 500);
    repeat (DIV) cycle();
    check("big_999", int'(fo1), 999);
    cycle();
    check("big_run", int'(st1), 2);

    // async reset mid-accel, no clock edge in between
    check("pre_rst_state", int'(st0), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_freq", int'(fo0), 0);
    check("rst_state", int'(st0), 0);
    check("rst_running", int'(rn0), 0);
    check("rst_at_speed", int'(as1), 0);
    check("rst_fault", int'(ft0), 0);
    run_en = 1'b0;
    #1 rst_n = 1'b1;
    cycle();

    // random run/stop/setpoint/estop traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) run_en = ~run_en;
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0) freq_set = 10'($urandom_range(0, 1023));
        else                           freq_set = 10'($urandom_range(0, 40));
      end
      estop = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
